// File: rtl/busy_bit_table.sv
// busy_bit_table: per-entry busy/ready tracker for renamed physical registers.
// Index-coded set (rename) and clear (writeback) requests are decoded into
// one-hot masks and applied to a registered WIDTH-bit busy vector. The
// population count and the all/none flags are registered from the next
// state, so they never add a popcount tree behind busy_vec on the output path.
//
// Optional feature macro: BUSY_TABLE_BYPASS_EN
//   defined   -> rd_busy reads the next state (same-cycle set/clear/flush
//                are forwarded to the readers)
//   undefined -> rd_busy reads the registered busy vector only
module busy_bit_table #(
    parameter int WIDTH   = 64,
    parameter int NUM_CLR = 2,
    parameter int NUM_RD  = 2,
    localparam int IW     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_valid,
    input  logic [IW-1:0]        set_idx,
    input  logic [NUM_CLR-1:0]   clr_valid,
    input  logic [IW-1:0]        clr_idx [NUM_CLR],
    input  logic                 flush,
    input  logic [IW-1:0]        rd_idx [NUM_RD],
    output logic [NUM_RD-1:0]    rd_busy,
    output logic [WIDTH-1:0]     busy_vec,
    output logic [IW:0]          busy_count,
    output logic                 all_busy,
    output logic                 none_busy,
    output logic                 err
);

    localparam logic [IW:0] WIDTH_C = (IW+1)'(WIDTH);

    // One-hot decode; an index at or above WIDTH shifts the 1 out and
    // yields an all-zero mask.
    function automatic logic [WIDTH-1:0] decode(input logic [IW-1:0] idx);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // True when the index names a real entry (only matters when WIDTH is
    // not a power of two).
    function automatic logic in_range(input logic [IW-1:0] idx);
        return ({1'b0, idx} < WIDTH_C);
    endfunction

    // Population count of a busy vector.
    function automatic logic [IW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [WIDTH-1:0]  busy_r;
    logic [IW:0]       count_r;
    logic              all_busy_r;
    logic              none_busy_r;
    logic              err_r;

    logic [WIDTH-1:0]  set_mask_s;
    logic [WIDTH-1:0]  clr_mask_s;
    logic [WIDTH-1:0]  next_s;
    logic [IW:0]       next_count_s;
    logic              range_err_s;
    logic              set_err_s;
    logic              clr_err_s;
    logic              err_evt_s;
    logic [WIDTH-1:0]  rd_src_s;
    logic [NUM_RD-1:0] rd_busy_s;

    // Decode set/clear requests into masks and collect range violations.
    always_comb begin
        set_mask_s  = '0;
        clr_mask_s  = '0;
        range_err_s = 1'b0;
        if (set_valid) begin
            set_mask_s = decode(set_idx);
            if (!in_range(set_idx)) begin
                range_err_s = 1'b1;
            end else begin
                range_err_s = range_err_s;
            end
        end else begin
            set_mask_s = '0;
        end
        for (int p = 0; p < NUM_CLR; p++) begin
            if (clr_valid[p]) begin
                clr_mask_s = clr_mask_s | decode(clr_idx[p]);
                if (!in_range(clr_idx[p])) begin
                    range_err_s = 1'b1;
                end else begin
                    range_err_s = range_err_s;
                end
            end else begin
                clr_mask_s = clr_mask_s;
            end
        end
    end

    // Protocol checks: double set, clear of an idle entry. Suppressed on flush.
    always_comb begin
        set_err_s = |(busy_r & set_mask_s & ~clr_mask_s);
        clr_err_s = 1'b0;
        for (int p = 0; p < NUM_CLR; p++) begin
            if (clr_valid[p] && in_range(clr_idx[p])) begin
                if (~|(busy_r & decode(clr_idx[p])) && ~|(set_mask_s & decode(clr_idx[p]))) begin
                    clr_err_s = 1'b1;
                end else begin
                    clr_err_s = clr_err_s;
                end
            end else begin
                clr_err_s = clr_err_s;
            end
        end
        if (flush) begin
            err_evt_s = 1'b0;
        end else begin
            err_evt_s = set_err_s | clr_err_s | range_err_s;
        end
    end

    // Next busy state: flush wins, then set wins over a same-cycle clear.
    always_comb begin
        if (flush) begin
            next_s = '0;
        end else begin
            next_s = (busy_r & ~clr_mask_s) | set_mask_s;
        end
        next_count_s = popcount(next_s);
    end

    // Busy state, count, flags and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= '0;
            count_r     <= '0;
            all_busy_r  <= 1'b0;
            none_busy_r <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            busy_r      <= next_s;
            count_r     <= next_count_s;
            all_busy_r  <= (next_count_s == WIDTH_C);
            none_busy_r <= (next_count_s == {(IW+1){1'b0}});
            err_r       <= err_r | err_evt_s;
        end
    end

    // Select the read source; the bypass read is held at zero during reset
    // so readers see reset values even if requests are still asserted.
    always_comb begin
`ifdef BUSY_TABLE_BYPASS_EN
        if (rst_n) begin
            rd_src_s = next_s;
        end else begin
            rd_src_s = '0;
        end
`else
        rd_src_s = busy_r;
`endif
    end

    // Indexed reads; out-of-range indices decode to zero and read 0.
    always_comb begin
        rd_busy_s = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_s[k] = |(rd_src_s & decode(rd_idx[k]));
        end
    end

    assign rd_busy    = rd_busy_s;
    assign busy_vec   = busy_r;
    assign busy_count = count_r;
    assign all_busy   = all_busy_r;
    assign none_busy  = none_busy_r;
    assign err        = err_r;

endmodule

// File: tb/tb_busy_bit_table.sv
// Directed self-checking bench for busy_bit_table: a 64-entry instance for the
// main behaviour and a 48-entry instance for out-of-range indices.
module tb_busy_bit_table;

    logic        clk;
    logic        rst_n;

    // 64-entry instance signals
    logic        set_valid;
    logic [5:0]  set_idx;
    logic [1:0]  clr_valid;
    logic [5:0]  clr_idx [2];
    logic        flush;
    logic [5:0]  rd_idx [2];
    logic [1:0]  rd_busy;
    logic [63:0] busy_vec;
    logic [6:0]  busy_count;
    logic        all_busy;
    logic        none_busy;
    logic        err;

    // 48-entry instance signals
    logic        s_set_valid;
    logic [5:0]  s_set_idx;
    logic [1:0]  s_clr_valid;
    logic [5:0]  s_clr_idx [2];
    logic        s_flush;
    logic [5:0]  s_rd_idx [2];
    logic [1:0]  s_rd_busy;
    logic [47:0] s_busy_vec;
    logic [6:0]  s_busy_count;
    logic        s_all_busy;
    logic        s_none_busy;
    logic        s_err;

    int passed;
    int total;

    busy_bit_table #(.WIDTH(64), .NUM_CLR(2), .NUM_RD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_valid(set_valid), .set_idx(set_idx),
        .clr_valid(clr_valid), .clr_idx(clr_idx),
        .flush(flush), .rd_idx(rd_idx), .rd_busy(rd_busy),
        .busy_vec(busy_vec), .busy_count(busy_count),
        .all_busy(all_busy), .none_busy(none_busy), .err(err)
    );

    busy_bit_table #(.WIDTH(48), .NUM_CLR(2), .NUM_RD(2)) dut48 (
        .clk(clk), .rst_n(rst_n),
        .set_valid(s_set_valid), .set_idx(s_set_idx),
        .clr_valid(s_clr_valid), .clr_idx(s_clr_idx),
        .flush(s_flush), .rd_idx(s_rd_idx), .rd_busy(s_rd_busy),
        .busy_vec(s_busy_vec), .busy_count(s_busy_count),
        .all_busy(s_all_busy), .none_busy(s_none_busy), .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n = 1'b0;
        set_valid = 1'b0; set_idx = 6'd0; clr_valid = 2'b00;
        clr_idx[0] = 6'd0; clr_idx[1] = 6'd0; flush = 1'b0;
        rd_idx[0] = 6'd0; rd_idx[1] = 6'd0;
        s_set_valid = 1'b0; s_set_idx = 6'd0; s_clr_valid = 2'b00;
        s_clr_idx[0] = 6'd0; s_clr_idx[1] = 6'd0; s_flush = 1'b0;
        s_rd_idx[0] = 6'd0; s_rd_idx[1] = 6'd0;

        // Reset state
        #12;
        check("rst_busy_vec", busy_vec, 64'h0);
        check("rst_count", {57'd0, busy_count}, 64'd0);
        check("rst_none", {63'd0, none_busy}, 64'd1);
        check("rst_all", {63'd0, all_busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_rd_busy", {62'd0, rd_busy}, 64'd0);
        rst_n = 1'b1;

        // Set 5 then 63
        set_valid = 1'b1; set_idx = 6'd5;
        tick();
        set_idx = 6'd63;
        tick();
        set_valid = 1'b0;
        check("set2_vec", busy_vec, 64'h8000_0000_0000_0020);
        check("set2_count", {57'd0, busy_count}, 64'd2);
        check("set2_none", {63'd0, none_busy}, 64'd0);
        check("set2_err", {63'd0, err}, 64'd0);

        // Same-cycle set and clear of 5: set wins, no error
        set_valid = 1'b1; set_idx = 6'd5; clr_valid = 2'b01; clr_idx[0] = 6'd5;
        tick();
        set_valid = 1'b0;
        check("setclr_vec", busy_vec, 64'h8000_0000_0000_0020);
        check("setclr_err", {63'd0, err}, 64'd0);
        // Both clear ports on 5: acts as one clear
        clr_valid = 2'b11; clr_idx[0] = 6'd5; clr_idx[1] = 6'd5;
        tick();
        clr_valid = 2'b00;
        check("dupclr_vec", busy_vec, 64'h8000_0000_0000_0000);
        check("dupclr_count", {57'd0, busy_count}, 64'd1);
        check("dupclr_err", {63'd0, err}, 64'd0);

        // Flush, then fill all 64 entries
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_vec", busy_vec, 64'h0);
        for (int i = 0; i < 63; i++) begin
            set_valid = 1'b1; set_idx = 6'(i);
            tick();
        end
        check("fill63_count", {57'd0, busy_count}, 64'd63);
        check("fill63_all", {63'd0, all_busy}, 64'd0);
        set_idx = 6'd63;
        tick();
        check("fill_vec", busy_vec, 64'hFFFF_FFFF_FFFF_FFFF);
        check("fill_count", {57'd0, busy_count}, 64'd64);
        check("fill_all", {63'd0, all_busy}, 64'd1);
        check("fill_err", {63'd0, err}, 64'd0);
        // Flush with a same-cycle set: flush wins
        flush = 1'b1; set_idx = 6'd3;
        tick();
        flush = 1'b0; set_valid = 1'b0;
        check("flushset_vec", busy_vec, 64'h0);
        check("flushset_none", {63'd0, none_busy}, 64'd1);
        check("flushset_count", {57'd0, busy_count}, 64'd0);

        // Read of entry 9 while it is cleared the same cycle
        set_valid = 1'b1; set_idx = 6'd9;
        tick();
        set_valid = 1'b0;
        clr_valid = 2'b01; clr_idx[0] = 6'd9; rd_idx[0] = 6'd9; rd_idx[1] = 6'd8;
        #1;
`ifdef BUSY_TABLE_BYPASS_EN
        check("rd_same_cycle", {63'd0, rd_busy[0]}, 64'd0);
`else
        check("rd_same_cycle", {63'd0, rd_busy[0]}, 64'd1);
`endif
        check("rd_idle_entry", {63'd0, rd_busy[1]}, 64'd0);
        tick();
        clr_valid = 2'b00;
        check("rd_next_cycle", {63'd0, rd_busy[0]}, 64'd0);
        check("rd_clr_err", {63'd0, err}, 64'd0);

        // Double set of 7 raises sticky err, survives flush
        set_valid = 1'b1; set_idx = 6'd7;
        tick();
        check("set7_err", {63'd0, err}, 64'd0);
        tick();
        set_valid = 1'b0;
        check("dblset_err", {63'd0, err}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("err_sticky_flush", {63'd0, err}, 64'd1);

        // Mid-cycle async reset with an entry busy
        set_valid = 1'b1; set_idx = 6'd1;
        tick();
        set_valid = 1'b0;
        check("pre_rst_vec", busy_vec, 64'h2);
        rst_n = 1'b0;
        #1;
        check("async_rst_vec", busy_vec, 64'h0);
        check("async_rst_count", {57'd0, busy_count}, 64'd0);
        check("async_rst_none", {63'd0, none_busy}, 64'd1);
        check("async_rst_all", {63'd0, all_busy}, 64'd0);
        check("async_rst_err", {63'd0, err}, 64'd0);
        #1;
        rst_n = 1'b1;

        // Clear of an idle entry after a fresh reset
        clr_valid = 2'b01; clr_idx[0] = 6'd2;
        tick();
        clr_valid = 2'b00;
        check("idle_clr_err", {63'd0, err}, 64'd1);
        check("idle_clr_vec", busy_vec, 64'h0);

        // 48-entry instance: last valid entry, then an out-of-range set
        s_set_valid = 1'b1; s_set_idx = 6'd47;
        tick();
        check("w48_set47_vec", {16'd0, s_busy_vec}, 64'h0000_8000_0000_0000);
        check("w48_set47_err", {63'd0, s_err}, 64'd0);
        s_set_idx = 6'd50;
        tick();
        s_set_valid = 1'b0;
        check("w48_oor_vec", {16'd0, s_busy_vec}, 64'h0000_8000_0000_0000);
        check("w48_oor_err", {63'd0, s_err}, 64'd1);
        s_rd_idx[0] = 6'd47; s_rd_idx[1] = 6'd50;
        #1;
        check("w48_rd_valid", {63'd0, s_rd_busy[0]}, 64'd1);
        check("w48_rd_oor", {63'd0, s_rd_busy[1]}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
